// File: rtl/bcd_mode_counter_pkg.sv
// rtl/bcd_mode_counter_pkg.sv - shared mode/state encodings and BCD constants
package bcd_mode_counter_pkg;

   // Step modes; the FSM state uses the same encoding as the mode input.
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_ADD1 = 2'b01;
   localparam logic [1:0] MODE_ADD2 = 2'b10;
   localparam logic [1:0] MODE_SUB1 = 2'b11;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      ST_HOLD = MODE_HOLD,
      ST_ADD1 = MODE_ADD1,
      ST_ADD2 = MODE_ADD2,
      ST_SUB1 = MODE_SUB1
   } state_e;

   // Values above nine are not legal BCD; pin them to nine on load.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
   endfunction

endpackage

// File: rtl/bcd_mode_counter_if.sv
// rtl/bcd_mode_counter_if.sv - control and display bundle of the BCD mode counter
interface bcd_mode_counter_if #(
   parameter int DIGITS = 2
);
   logic                  en;
   logic [1:0]            mode;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count_bcd;
   logic [1:0]            state;
   logic                  wrap;
   logic                  sat;
   logic [7*DIGITS-1:0]   hex;

   modport master (
      output en, mode, load, load_val,
      input  count_bcd, state, wrap, sat, hex
   );

   modport slave (
      input  en, mode, load, load_val,
      output count_bcd, state, wrap, sat, hex
   );
endinterface

// File: rtl/bcd_mode_counter_digit_step.sv
// rtl/bcd_mode_counter_digit_step.sv - one decimal digit of the step adder with carry/borrow ripple
module bcd_digit_step
   import bcd_mode_counter_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic [1:0] step_i,   // own delta in mode encoding: 0, +1, +2, -1
   input  logic       sub_i,    // carry_i means a borrow when counting down
   input  logic       carry_i,
   output logic [3:0] digit_o,
   output logic       carry_o
);

   logic signed [5:0] sum;

   // Digit plus own delta plus incoming carry/borrow, folded back into 0..9.
   always_comb begin
      sum = $signed({2'b00, digit_i});
      case (step_i)
         MODE_ADD1: sum = sum + 6'sd1;
         MODE_ADD2: sum = sum + 6'sd2;
         MODE_SUB1: sum = sum - 6'sd1;
         default:   sum = sum;
      endcase
      if (carry_i) begin
         sum = sub_i ? (sum - 6'sd1) : (sum + 6'sd1);
      end
      digit_o = 4'(sum);
      carry_o = 1'b0;
      if (sum > 6'sd9) begin
         digit_o = 4'(sum - 6'sd10);
         carry_o = 1'b1;
      end else if (sum < 6'sd0) begin
         digit_o = 4'(sum + 6'sd10);
         carry_o = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_mode_counter_seg7.sv
// rtl/bcd_mode_counter_seg7.sv - BCD digit to active-low seven-segment decoder
module BCD_to_seven_segment (
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o    // {g,f,e,d,c,b,a}, 0 lights a segment
);

   // Plain lookup; non-BCD codes blank the digit.
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = 7'b1000000;
         4'd1:    seg_o = 7'b1111001;
         4'd2:    seg_o = 7'b0100100;
         4'd3:    seg_o = 7'b0110000;
         4'd4:    seg_o = 7'b0011001;
         4'd5:    seg_o = 7'b0010010;
         4'd6:    seg_o = 7'b0000010;
         4'd7:    seg_o = 7'b1111000;
         4'd8:    seg_o = 7'b0000000;
         4'd9:    seg_o = 7'b0010000;
         default: seg_o = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/bcd_mode_counter.sv
// rtl/bcd_mode_counter.sv - multi-digit BCD counter stepped by a registered mode FSM
module bcd_mode_counter
   import bcd_mode_counter_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter bit SATURATE = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   bcd_mode_counter_if.slave bus
);

   localparam int W = 4 * DIGITS;

   state_e          state_q, state_d;
   logic [W-1:0]    count_q, count_d;
   logic            wrap_q, wrap_d;
   logic            sat_q, sat_d;

   logic [W-1:0]    stepped;
   logic [W-1:0]    loaded;
   logic [W-1:0]    clamp_val;
   logic [DIGITS:0] carry;
   logic [1:0]      digit_step [DIGITS];
   logic            sub_dir;
   logic            overflow;

   assign sub_dir  = (state_q == ST_SUB1);
   assign carry[0] = 1'b0;
   // A carry out of the top digit is the only way the count leaves 0..10^DIGITS-1.
   assign overflow = carry[DIGITS];
   assign clamp_val = sub_dir ? '0 : {DIGITS{BCD_MAX_DIGIT}};

   // Only the least significant digit applies the step; the rest see carries.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
         assign digit_step[g] = state_q;
      end else begin : g_upper
         assign digit_step[g] = MODE_HOLD;
      end

      bcd_digit_step u_step (
         .digit_i (count_q[4*g +: 4]),
         .step_i  (digit_step[g]),
         .sub_i   (sub_dir),
         .carry_i (carry[g]),
         .digit_o (stepped[4*g +: 4]),
         .carry_o (carry[g+1])
      );

      assign loaded[4*g +: 4] = clamp_digit(bus.load_val[4*g +: 4]);

      BCD_to_seven_segment u_seg (
         .bcd_i (count_q[4*g +: 4]),
         .seg_o (bus.hex[7*g +: 7])
      );
   end

   // Next state follows mode directly; count uses load > enable > step priority.
   always_comb begin
      state_d = state_e'(bus.mode);
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = sat_q;
      if (bus.load) begin
         count_d = loaded;
         sat_d   = 1'b0;
      end else if (bus.en) begin
         if (state_q == ST_HOLD) begin
            sat_d = 1'b0;
         end else if (overflow && SATURATE) begin
            count_d = clamp_val;
            sat_d   = 1'b1;
         end else if (overflow) begin
            count_d = stepped;
            wrap_d  = 1'b1;
            sat_d   = 1'b0;
         end else begin
            count_d = stepped;
            sat_d   = 1'b0;
         end
      end
   end

   // State, count and status registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_HOLD;
         count_q <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.count_bcd = count_q;
   assign bus.state     = state_q;
   assign bus.wrap      = wrap_q;
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_bcd_mode_counter.sv
// tb/tb_bcd_mode_counter.sv - self-checking bench for wrap and saturate counter variants
module tb_bcd_mode_counter;

   localparam int M = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       ld;
   logic [1:0] mode;
   logic [7:0] lv;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_mode_counter_if #(.DIGITS(2)) if_w ();
   bcd_mode_counter_if #(.DIGITS(2)) if_s ();

   assign if_w.en = en;  assign if_w.mode = mode;  assign if_w.load = ld;  assign if_w.load_val = lv;
   assign if_s.en = en;  assign if_s.mode = mode;  assign if_s.load = ld;  assign if_s.load_val = lv;

   bcd_mode_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_w (.clk_i(clk), .reset_i(rst), .bus(if_w.slave));
   bcd_mode_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_s (.clk_i(clk), .reset_i(rst), .bus(if_s.slave));

   // Reference model: plain integer count, index 0 = wrap variant, 1 = saturate variant.
   int m_cnt [2];
   int m_state;
   int m_wrap [2];
   int m_sat [2];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int to_bcd(input int v);
      return ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   function automatic int seg(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic int load_value(input logic [7:0] x);
      int hi, lo;
      hi = int'(x[7:4]);
      lo = int'(x[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      return hi * 10 + lo;
   endfunction

   task automatic model_edge();
      int prev, amt, v;
      if (rst) begin
         m_state = 0;
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
         end
         return;
      end
      prev    = m_state;
      m_state = int'(mode);
      amt     = (prev == 3) ? -1 : prev;
      for (int k = 0; k < 2; k++) begin
         if (ld) begin
            m_cnt[k] = load_value(lv); m_wrap[k] = 0; m_sat[k] = 0;
         end else if (!en) begin
            m_wrap[k] = 0;
         end else begin
            v = m_cnt[k] + amt;
            m_wrap[k] = 0;
            m_sat[k]  = 0;
            if (v >= M || v < 0) begin
               if (k == 1) begin
                  v = (v < 0) ? 0 : M - 1;
                  m_sat[k] = 1;
               end else begin
                  v = (v < 0) ? v + M : v - M;
                  m_wrap[k] = 1;
               end
            end
            m_cnt[k] = v;
         end
      end
   endtask

   task automatic check_all();
      chk("w_count", int'(if_w.count_bcd), to_bcd(m_cnt[0]));
      chk("w_state", int'(if_w.state), m_state);
      chk("w_wrap",  int'(if_w.wrap), m_wrap[0]);
      chk("w_sat",   int'(if_w.sat), 0);
      chk("w_hex",   int'(if_w.hex), seg(m_cnt[0] / 10) * 128 + seg(m_cnt[0] % 10));
      chk("s_count", int'(if_s.count_bcd), to_bcd(m_cnt[1]));
      chk("s_state", int'(if_s.state), m_state);
      chk("s_wrap",  int'(if_s.wrap), 0);
      chk("s_sat",   int'(if_s.sat), m_sat[1]);
      chk("s_hex",   int'(if_s.hex), seg(m_cnt[1] / 10) * 128 + seg(m_cnt[1] % 10));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input bit r, input bit e, input bit [1:0] md, input bit l, input bit [7:0] v);
      rst = r; en = e; mode = md; ld = l; lv = v;
   endtask

   typedef struct {
      bit       r;
      bit       e;
      bit [1:0] md;
      bit       l;
      bit [7:0] v;
      int       cnt;
      int       st;
      int       w;
   } vec_t;

   vec_t tv [28];

   initial begin
      set_in(1, 0, 2'd0, 0, 8'h00);
      m_state = 0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
      end

      // Expectations for the wrap variant, written out by hand.
      tv[0]  = '{1, 1, 2'd1, 0, 8'h00, 'h00, 0, 0};
      tv[1]  = '{0, 1, 2'd1, 0, 8'h00, 'h00, 1, 0};
      tv[2]  = '{0, 1, 2'd1, 0, 8'h00, 'h01, 1, 0};
      tv[3]  = '{0, 1, 2'd1, 0, 8'h00, 'h02, 1, 0};
      tv[4]  = '{0, 1, 2'd1, 1, 8'h98, 'h98, 1, 0};
      tv[5]  = '{0, 1, 2'd1, 0, 8'h00, 'h99, 1, 0};
      tv[6]  = '{0, 1, 2'd1, 0, 8'h00, 'h00, 1, 1};
      tv[7]  = '{0, 1, 2'd1, 0, 8'h00, 'h01, 1, 0};
      tv[8]  = '{0, 1, 2'd2, 1, 8'h98, 'h98, 2, 0};
      tv[9]  = '{0, 1, 2'd2, 0, 8'h00, 'h00, 2, 1};
      tv[10] = '{0, 1, 2'd2, 1, 8'h99, 'h99, 2, 0};
      tv[11] = '{0, 1, 2'd2, 0, 8'h00, 'h01, 2, 1};
      tv[12] = '{0, 1, 2'd2, 1, 8'h09, 'h09, 2, 0};
      tv[13] = '{0, 1, 2'd2, 0, 8'h00, 'h11, 2, 0};
      tv[14] = '{0, 1, 2'd3, 1, 8'h00, 'h00, 3, 0};
      tv[15] = '{0, 1, 2'd3, 0, 8'h00, 'h99, 3, 1};
      tv[16] = '{0, 1, 2'd3, 0, 8'h00, 'h98, 3, 0};
      tv[17] = '{0, 1, 2'd3, 1, 8'h10, 'h10, 3, 0};
      tv[18] = '{0, 1, 2'd3, 0, 8'h00, 'h09, 3, 0};
      tv[19] = '{0, 1, 2'd1, 1, 8'hAF, 'h99, 1, 0};
      tv[20] = '{0, 0, 2'd1, 0, 8'h00, 'h99, 1, 0};
      tv[21] = '{0, 0, 2'd2, 0, 8'h00, 'h99, 2, 0};
      tv[22] = '{0, 1, 2'd1, 0, 8'h00, 'h01, 1, 1};
      tv[23] = '{1, 1, 2'd1, 0, 8'h00, 'h00, 0, 0};
      tv[24] = '{0, 1, 2'd1, 0, 8'h00, 'h00, 1, 0};
      tv[25] = '{0, 1, 2'd1, 0, 8'h00, 'h01, 1, 0};
      tv[26] = '{0, 1, 2'd0, 0, 8'h00, 'h02, 0, 0};
      tv[27] = '{0, 1, 2'd0, 0, 8'h00, 'h02, 0, 0};

      for (int i = 0; i < 28; i++) begin
         set_in(tv[i].r, tv[i].e, tv[i].md, tv[i].l, tv[i].v);
         tick();
         chk($sformatf("tv%0d_count", i), int'(if_w.count_bcd), tv[i].cnt);
         chk($sformatf("tv%0d_state", i), int'(if_w.state), tv[i].st);
         chk($sformatf("tv%0d_wrap", i),  int'(if_w.wrap), tv[i].w);
      end

      // Saturate variant: clamp, stale-state clamp, sat hold on en=0, clears.
      set_in(0, 1, 2'd2, 1, 8'h97); tick();
      chk("sat_load97", int'(if_s.count_bcd), 'h97);
      set_in(0, 1, 2'd2, 0, 8'h00); tick();
      chk("sat_99_exact", int'(if_s.count_bcd), 'h99); chk("sat_99_exact_flag", int'(if_s.sat), 0);
      tick();
      chk("sat_clamp_hi", int'(if_s.count_bcd), 'h99); chk("sat_clamp_hi_flag", int'(if_s.sat), 1);
      set_in(0, 0, 2'd2, 0, 8'h00); tick();
      chk("sat_hold_en0", int'(if_s.sat), 1);
      set_in(0, 1, 2'd3, 0, 8'h00); tick();
      chk("sat_stale", int'(if_s.count_bcd), 'h99); chk("sat_stale_flag", int'(if_s.sat), 1);
      tick();
      chk("sat_sub", int'(if_s.count_bcd), 'h98); chk("sat_sub_flag", int'(if_s.sat), 0);
      set_in(0, 1, 2'd3, 1, 8'h00); tick();
      set_in(0, 1, 2'd3, 0, 8'h00); tick();
      chk("sat_clamp_lo", int'(if_s.count_bcd), 'h00); chk("sat_clamp_lo_flag", int'(if_s.sat), 1);
      set_in(0, 1, 2'd3, 1, 8'h05); tick();
      chk("sat_load_clr", int'(if_s.sat), 0); chk("sat_wrap_zero", int'(if_s.wrap), 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         set_in(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
                2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), 8'($urandom));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
